// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and counter width helpers
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Width of a counter holding values 0..n-1, never narrower than one bit
  function automatic int uart_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DBITS_DEF      = 8;
  localparam int UART_TICK_W_DEF     = uart_cnt_w(UART_OVERSAMPLE_DEF);
  localparam int UART_BIT_W_DEF      = uart_cnt_w(UART_DBITS_DEF + 1);

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - free-running oversample tick, one pulse every DIVISOR clocks
module baud_gen
  import uart_pkg::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = uart_cnt_w(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIVISOR-1 and flag the wrap
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider state, restarted by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; UART_RX_PARITY_EN enables the parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DBITS      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             full,
  output logic [DBITS-1:0] data,
  output logic             inc,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int TICK_W = uart_cnt_w(OVERSAMPLE);
  localparam int BIT_W  = uart_cnt_w(DBITS + 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DBITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: OVERSAMPLE must be even and >= 8, PARITY_ODD must be 0 or 1");
  end

  logic tick;

  baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic              rx_meta_q, rx_s_q;
  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DBITS-1:0]  shift_q, shift_d;
  logic [DBITS-1:0]  data_q, data_d;
  logic              inc_q, inc_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              parity_err_q, parity_err_d;
  logic              armed_q, armed_d;
  logic              par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;

  // Received parity bit against the parity computed over the shifted byte
  always_comb begin
    par_bad = par_bit_q != ((^shift_q) ^ (PARITY_ODD != 0));
  end
`else
  // No parity bit in the frame
  always_comb begin
    par_bad = 1'b0;
  end
`endif

  // Two-flop synchroniser; idles high so reset does not fake a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM: next state, counters, shift register and registered pulses
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    inc_d        = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    armed_d      = armed_q | rx_s_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            state_d    = rx_s_q ? ST_IDLE : ST_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            shift_d    = {rx_s_q, shift_q[DBITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
              bit_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            par_bit_d  = rx_s_q;
            state_d    = ST_STOP;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A low stop bit also disarms, so a held break cannot retrigger
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
            if (par_bad) begin
              parity_err_d = 1'b1;
            end
            if (rx_s_q && !par_bad) begin
              if (full) begin
                overrun_d = 1'b1;
              end else begin
                inc_d  = 1'b1;
                data_d = shift_q;
              end
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      inc_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      armed_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      inc_q        <= inc_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      armed_q      <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  assign data       = data_q;
  assign inc        = inc_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx; UART_RX_PARITY_EN adds parity frames
module tb_uart_rx;

  localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic [7:0] data;
  logic       inc, busy, frame_err, overrun, parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_inc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int b_inc, b_ferr, b_ovr, b_perr;
  logic [7:0] sb[$];

  uart_rx #(.DIVISOR(2), .OVERSAMPLE(16), .DBITS(8), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .full       (full),
    .data       (data),
    .inc        (inc),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every write strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (inc) begin
        n_inc++;
        check_eq("inc_with_full", {31'd0, full}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_inc", sb.size(), 32'd1);
        end else begin
          check_eq("sb_data", {24'd0, data}, {24'd0, sb.pop_front()});
        end
      end
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
    end
  end

  task automatic snap();
    b_inc = n_inc; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
  endtask

  task automatic check_deltas(input string tag, input int d_inc, input int d_ferr,
                              input int d_ovr, input int d_perr);
    check_eq({tag, "_inc"},  n_inc - b_inc,   d_inc);
    check_eq({tag, "_ferr"}, n_ferr - b_ferr, d_ferr);
    check_eq({tag, "_ovr"},  n_ovr - b_ovr,   d_ovr);
    check_eq({tag, "_perr"}, n_perr - b_perr, d_perr);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Start, LSB-first data, optional parity (even, optionally inverted), stop
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit((^b) ^ par_flip);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic busy_seen;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data", {24'd0, data}, 32'd0);
    check_eq("rst_inc", {31'd0, inc}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Single frame
    snap();
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("a5");
    check_deltas("a5", 1, 0, 0, 0);
    check_eq("a5_data", {24'd0, data}, 32'hA5);

    // Back-to-back frames, no idle gap
    snap();
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("b2b");
    check_deltas("b2b", 2, 0, 0, 0);
    check_eq("b2b_data", {24'd0, data}, 32'hFF);

    // Start glitch of 4 ticks
    snap();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check_eq("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check_deltas("glitch", 0, 0, 0, 0);

    // Bad stop bit followed by a long break
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40 * BIT_CLK; i++) begin
      @(negedge clk);
      if (i > 4 && busy) busy_seen = 1'b1;
    end
    check_eq("break_no_restart", {31'd0, busy_seen}, 32'd0);
    check_deltas("break", 0, 1, 0, 0);
    check_eq("break_data", {24'd0, data}, 32'hFF);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    snap();
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("after_break");
    check_deltas("after_break", 1, 0, 0, 0);
    check_eq("after_break_data", {24'd0, data}, 32'h11);

    // Overrun: FIFO full across the stop bit
    snap();
    full = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    full = 1'b0;
    wait_idle("ovr");
    check_deltas("ovr", 0, 0, 1, 0);
    check_eq("ovr_data", {24'd0, data}, 32'h11);

    // Reset in the middle of the data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_data", {24'd0, data}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_pulses", {28'd0, inc, frame_err, overrun, parity_err}, 32'd0);
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    snap();
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("post_rst");
    check_deltas("post_rst", 1, 0, 0, 0);
    check_eq("post_rst_data", {24'd0, data}, 32'h96);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("par_bad");
    check_deltas("par_bad", 0, 0, 0, 1);
    check_eq("par_bad_data", {24'd0, data}, 32'h96);
    snap();
    sb.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    wait_idle("par_ok");
    check_deltas("par_ok", 1, 0, 0, 0);
    check_eq("par_ok_data", {24'd0, data}, 32'h01);
`endif

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
